set_bit_iterator: RTL and testbench
===================================

SET_BIT_ITERATOR -- requirements
Module: set_bit_iterator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the input vector width; legal values are WIDTH >= 1.
REQ-002 SHALL have parameter MODE, default 1'b0, meaning the scan order: 0 = LSB-first (trailing), 1 = MSB-first (leading).
REQ-003 SHALL have dependent parameter CNT_WIDTH, default 1 if WIDTH==1 else $clog2(WIDTH), meaning the index width; not to be overridden.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port flush_i, input, 1 bit: abandons the vector in flight.
REQ-007 SHALL have port in_valid_i, input, 1 bit: in_vec_i is valid.
REQ-008 SHALL have port in_ready_o, output, 1 bit: the block can accept a vector.
REQ-009 SHALL have port in_vec_i, input, WIDTH bits: the vector to iterate.
REQ-010 SHALL have port idx_valid_o, output, 1 bit: the current index beat is valid.
REQ-011 SHALL have port idx_ready_i, input, 1 bit: the consumer accepts the beat.
REQ-012 SHALL have port idx_o, output, CNT_WIDTH bits: the bit position of a set bit.
REQ-013 SHALL have port idx_seq_o, output, CNT_WIDTH+1 bits: the ordinal of the beat within the vector, starting at 0.
REQ-014 SHALL have port idx_last_o, output, 1 bit: this is the final beat for the vector.
REQ-015 SHALL have port idx_empty_o, output, 1 bit: the accepted vector was all zero.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and SCAN, with an internal WIDTH-bit remaining register and a CNT_WIDTH+1-bit sequence counter.
REQ-017 In IDLE, the block SHALL drive in_ready_o=1 and idx_valid_o=0; in SCAN, it SHALL drive in_ready_o=0 and idx_valid_o=1.
REQ-018 On in_valid_i & in_ready_o, the block SHALL load remaining <= in_vec_i, clear the sequence counter and a zero-flag <= ~|in_vec_i, then go to SCAN; the first beat SHALL be valid the next cycle (latency 1).
REQ-019 In SCAN, idx_o SHALL be the position of the lowest (MODE=0) or highest (MODE=1) set bit of remaining, computed combinationally from registered state only.
REQ-020 In SCAN, idx_last_o SHALL be 1 iff remaining has at most one set bit.
REQ-021 In SCAN, idx_empty_o SHALL be 1 iff the zero-flag is set; in that case the block SHALL present exactly one beat with idx_o=0, idx_seq_o=0, idx_last_o=1.
REQ-022 In SCAN, idx_seq_o SHALL equal the sequence counter.
REQ-023 On idx_valid_o & idx_ready_i with idx_last_o=0, the block SHALL clear the bit at idx_o in remaining and increment the sequence counter.
REQ-024 On idx_valid_o & idx_ready_i with idx_last_o=1, the block SHALL go to IDLE and clear remaining.
REQ-025 While idx_valid_o=1 & idx_ready_i=0, idx_o, idx_seq_o, idx_last_o and idx_empty_o SHALL be held stable.
REQ-026 in_ready_o SHALL NOT depend combinationally on any input; the block SHALL NOT accept a new vector in the same cycle as a last-beat handshake.
REQ-027 Each beat of one vector SHALL report a distinct position, in strictly increasing (MODE=0) or decreasing (MODE=1) order, and the number of beats SHALL equal popcount(vector), or 1 for a zero vector.
REQ-028 flush_i=1 SHALL force IDLE next cycle, clear remaining and the counter, and take priority over every handshake that cycle; while in IDLE, flush_i SHALL also block acceptance that cycle.
REQ-029 With WIDTH=1, the block SHALL emit idx_o=0 with idx_last_o=1 for input 1, and the empty beat for input 0.
REQ-030 in_vec_i SHALL be ignored when no input handshake occurs.

Reset
REQ-031 While rst_i=1 at a clock edge, the next state SHALL be IDLE with remaining=0, counter=0 and zero-flag=0; rst_i SHALL override flush_i and all handshakes.
REQ-032 While rst_i is asserted, in_ready_o and idx_valid_o SHALL be 0; after deassertion, in_ready_o SHALL be 1 and idx_o, idx_seq_o, idx_last_o, idx_empty_o SHALL be 0.
REQ-033 A reset in mid-SCAN SHALL discard the vector, with no further beats for it.

Verification
REQ-034 With WIDTH=8, MODE=0, vec=8'b1010_0100 and idx_ready_i=1, the block SHALL emit idx 2,5,7, seq 0,1,2, last only on 7, empty=0, then in_ready_o=1 the cycle after.
REQ-035 With MODE=1 and the same vector, the block SHALL emit idx 7,5,2 with last on 2.
REQ-036 With vec=8'h00, the block SHALL emit one beat: idx=0, seq=0, last=1, empty=1.
REQ-037 With vec=8'hFF, MODE=0, and idx_ready_i low for 3 cycles on beat 3, the block SHALL emit idx 0..7 and hold idx=3/seq=3 stable during the stall, with last only on 7.
REQ-038 With vec=8'h81, flush_i pulsed after the first beat is accepted, the block SHALL show no beat for 7, idx_valid_o=0 and in_ready_o=1 the next cycle.
REQ-039 With rst_i asserted in mid-SCAN of 8'hF0 after 2 beats, the block SHALL show no further beats and idle outputs; a new vector 8'h01 SHALL then yield a single beat idx=0, seq=0, last=1.

Source files
------------

// File: rtl/set_bit_iterator.sv
// Walks the set bits of an accepted vector, one index beat per valid/ready handshake.
// An all-zero vector produces a single beat flagged empty.
module set_bit_iterator #(
    parameter int   WIDTH     = 16,
    parameter logic MODE      = 1'b0,
    parameter int   CNT_WIDTH = (WIDTH == 1) ? 1 : $clog2(WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_vec_i,
    output logic                 idx_valid_o,
    input  logic                 idx_ready_i,
    output logic [CNT_WIDTH-1:0] idx_o,
    output logic [CNT_WIDTH:0]   idx_seq_o,
    output logic                 idx_last_o,
    output logic                 idx_empty_o
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t               state;
    logic [WIDTH-1:0]     remaining;
    logic [CNT_WIDTH:0]   seq;
    logic                 zero_flag;
    logic                 in_reset;

    logic [CNT_WIDTH-1:0] pick_idx;
    logic [WIDTH-1:0]     pick_mask;
    logic                 at_most_one;
    logic                 scanning;

    // Priority pick over the remaining bits; the last match in loop order wins.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        pick_idx  = '0;
        pick_mask = '0;
        if (MODE == 1'b0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (remaining[i]) begin
                    pick_idx     = CNT_WIDTH'(i);
                    pick_mask    = '0;
                    pick_mask[i] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (remaining[i]) begin
                    pick_idx     = CNT_WIDTH'(i);
                    pick_mask    = '0;
                    pick_mask[i] = 1'b1;
                end
            end
        end
    end

    assign at_most_one = (remaining & (remaining - WIDTH'(1))) == '0;
    assign scanning    = (state == SCAN);

    // in_reset keeps in_ready low while reset is held, using only registered state.
    assign in_ready_o  = (state == IDLE) && !in_reset;
    assign idx_valid_o = scanning;
    assign idx_o       = scanning ? pick_idx : '0;
    assign idx_seq_o   = scanning ? seq : '0;
    assign idx_last_o  = scanning && at_most_one;
    assign idx_empty_o = scanning && zero_flag;

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state     <= IDLE;
            remaining <= '0;
            seq       <= '0;
            zero_flag <= 1'b0;
            in_reset  <= 1'b1;
        end else begin
            in_reset <= 1'b0;
            if (flush_i) begin
                state     <= IDLE;
                remaining <= '0;
                seq       <= '0;
                zero_flag <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid_i && in_ready_o) begin
                            remaining <= in_vec_i;
                            seq       <= '0;
                            zero_flag <= ~|in_vec_i;
                            state     <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (idx_ready_i) begin
                            if (at_most_one) begin
                                state     <= IDLE;
                                remaining <= '0;
                                seq       <= '0;
                                zero_flag <= 1'b0;
                            end else begin
                                remaining <= remaining & ~pick_mask;
                                seq       <= seq + (CNT_WIDTH + 1)'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_set_bit_iterator.sv
// Scoreboard bench: three iterators (8-bit LSB-first, 8-bit MSB-first, 1-bit) share one
// stimulus stream; expected beats are queued at issue and popped by per-instance monitors.
module tb_set_bit_iterator;

    typedef struct {
        logic [2:0] idx;
        logic [3:0] seq;
        logic       last;
        logic       empty;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_vec = 8'h00;
    logic       idx_ready = 1'b1;

    logic       ir0, v0, l0, e0;
    logic [2:0] i0;
    logic [3:0] s0;
    logic       ir1, v1, l1, e1;
    logic [2:0] i1;
    logic [3:0] s1;
    logic       ir2, v2, l2, e2;
    logic [0:0] i2;
    logic [1:0] s2;

    beat_t q0[$];
    beat_t q1[$];
    beat_t q2[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    set_bit_iterator #(.WIDTH(8), .MODE(1'b0)) dut_lsb (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir0),
        .in_vec_i(in_vec), .idx_valid_o(v0), .idx_ready_i(idx_ready), .idx_o(i0),
        .idx_seq_o(s0), .idx_last_o(l0), .idx_empty_o(e0)
    );

    set_bit_iterator #(.WIDTH(8), .MODE(1'b1)) dut_msb (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir1),
        .in_vec_i(in_vec), .idx_valid_o(v1), .idx_ready_i(idx_ready), .idx_o(i1),
        .idx_seq_o(s1), .idx_last_o(l1), .idx_empty_o(e1)
    );

    set_bit_iterator #(.WIDTH(1), .MODE(1'b0)) dut_w1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir2),
        .in_vec_i(in_vec[0:0]), .idx_valid_o(v2), .idx_ready_i(idx_ready), .idx_o(i2),
        .idx_seq_o(s2), .idx_last_o(l2), .idx_empty_o(e2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic extra_beat(input string name, input logic [31:0] idx);
        n_checks++;
        $display("FAIL %s: got beat idx=%0d expected no beat", name, idx);
    endtask

    // Expected beats: ascending positions for LSB-first, descending for MSB-first.
    task automatic push_exp(input logic [7:0] v);
        beat_t b;
        int n;
        int k;
        n = $countones(v);
        if (n == 0) begin
            b = '{3'd0, 4'd0, 1'b1, 1'b1};
            q0.push_back(b);
            q1.push_back(b);
        end else begin
            k = 0;
            for (int i = 0; i < 8; i++) begin
                if (v[i]) begin
                    b = '{3'(i), 4'(k), (k == n - 1), 1'b0};
                    q0.push_back(b);
                    k++;
                end
            end
            k = 0;
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) begin
                    b = '{3'(i), 4'(k), (k == n - 1), 1'b0};
                    q1.push_back(b);
                    k++;
                end
            end
        end
        b = '{3'd0, 4'd0, 1'b1, !v[0]};
        q2.push_back(b);
    endtask

    task automatic send(input logic [7:0] v);
        int n = 0;
        while (!(ir0 && ir1 && ir2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(ir0 && ir1 && ir2), 32'd1);
        in_valid = 1'b1;
        in_vec   = v;
        push_exp(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_vec   = 8'h5A;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(ir0 && ir1 && ir2 && q0.size() == 0 && q1.size() == 0 && q2.size() == 0)
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", 32'(ir0 && ir1 && ir2 && q0.size() == 0 && q1.size() == 0 && q2.size() == 0), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 32'({ir0, ir1, ir2}), 32'b111);
        check({tag, "_valid"}, 32'({v0, v1, v2}), 32'b000);
        check({tag, "_idx"}, 32'({i0, i1, i2}), 32'd0);
        check({tag, "_seq"}, 32'({s0, s1, s2}), 32'd0);
        check({tag, "_last"}, 32'({l0, l1, l2}), 32'd0);
        check({tag, "_empty"}, 32'({e0, e1, e2}), 32'd0);
    endtask

    // Monitors: compare every presented beat; a beat completes only on ready.
    always @(negedge clk) begin
        if (!rst && !flush && v0) begin
            if (q0.size() == 0) extra_beat("lsb_extra_beat", 32'(i0));
            else begin
                check("lsb_idx", 32'(i0), 32'(q0[0].idx));
                check("lsb_seq", 32'(s0), 32'(q0[0].seq));
                check("lsb_last", 32'(l0), 32'(q0[0].last));
                check("lsb_empty", 32'(e0), 32'(q0[0].empty));
                if (idx_ready) q0.delete(0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && !flush && v1) begin
            if (q1.size() == 0) extra_beat("msb_extra_beat", 32'(i1));
            else begin
                check("msb_idx", 32'(i1), 32'(q1[0].idx));
                check("msb_seq", 32'(s1), 32'(q1[0].seq));
                check("msb_last", 32'(l1), 32'(q1[0].last));
                check("msb_empty", 32'(e1), 32'(q1[0].empty));
                if (idx_ready) q1.delete(0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && !flush && v2) begin
            if (q2.size() == 0) extra_beat("w1_extra_beat", 32'(i2));
            else begin
                check("w1_idx", 32'(i2), 32'(q2[0].idx));
                check("w1_seq", 32'(s2), 32'(q2[0].seq));
                check("w1_last", 32'(l2), 32'(q2[0].last));
                check("w1_empty", 32'(e2), 32'(q2[0].empty));
                if (idx_ready) q2.delete(0);
            end
        end
    end

    initial begin
        // Reset held: nothing ready, nothing valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'({ir0, ir1, ir2}), 32'b000);
        check("rst_valid", 32'({v0, v1, v2}), 32'b000);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("post_rst");

        // 1010_0100: LSB-first 2,5,7 / MSB-first 7,5,2.
        send(8'b1010_0100);
        wait_done();

        // Zero vector: one empty beat.
        send(8'h00);
        wait_done();

        // All ones with a 3-cycle stall on beat 3.
        send(8'hFF);
        repeat (3) @(posedge clk);
        #1 idx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 idx_ready = 1'b1;
        wait_done();

        // Flush after the first beat of 8'h81 is accepted.
        send(8'h81);
        @(posedge clk);
        #1;
        flush = 1'b1;
        q0.delete();
        q1.delete();
        q2.delete();
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'({v0, v1, v2}), 32'b000);
        check("flush_in_ready", 32'({ir0, ir1, ir2}), 32'b111);

        // Flush in IDLE blocks acceptance of a simultaneous vector.
        in_valid = 1'b1;
        in_vec   = 8'h3C;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check("flush_idle_valid", 32'({v0, v1, v2}), 32'b000);
        check("flush_idle_in_ready", 32'({ir0, ir1, ir2}), 32'b111);

        // Reset in mid-scan of 8'hF0 after two beats, then a fresh 8'h01.
        send(8'hF0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        q2.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_in_ready", 32'({ir0, ir1, ir2}), 32'b000);
        check("midrst_valid", 32'({v0, v1, v2}), 32'b000);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("after_midrst");
        send(8'h01);
        wait_done();

        repeat (3) @(negedge clk);
        check("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
